video_sync_gen: RTL



---
 rtl/video_sync_gen_pkg.sv | 74 +++++++
 rtl/video_sync_axis.sv | 115 +++++++++++
 rtl/video_sync_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/video_sync_gen_pkg.sv
// -----------------------------------------------------------------------------
// video_sync_gen_pkg
// Shared definitions for the raster timing generator:
//   - CNT_W        : width of the pixel / line counters (12 bits, totals <= 4096)
//   - H31_* / V31_*: 31 kHz 640x480 timing (the default build)
//   - H15_* / V15_*: 15 kHz 320x240 progressive preset
//   - axis_region_e: where a counter sits inside one line or one field
//   - axis_total() : sum of the four lengths of one axis
//   - axis_region(): classify a counter position against the region ends
// -----------------------------------------------------------------------------
package video_sync_gen_pkg;

  localparam int unsigned CNT_W = 12;

  // 31 kHz, 640x480 @ 60 Hz
  localparam int unsigned H31_ACTIVE = 640;
  localparam int unsigned H31_FP     = 16;
  localparam int unsigned H31_SYNC   = 96;
  localparam int unsigned H31_BP     = 48;
  localparam int unsigned V31_ACTIVE = 480;
  localparam int unsigned V31_FP     = 10;
  localparam int unsigned V31_SYNC   = 2;
  localparam int unsigned V31_BP     = 33;

  // 15 kHz, 320x240 progressive (262 lines per field)
  localparam int unsigned H15_ACTIVE = 320;
  localparam int unsigned H15_FP     = 16;
  localparam int unsigned H15_SYNC   = 32;
  localparam int unsigned H15_BP     = 40;
  localparam int unsigned V15_ACTIVE = 240;
  localparam int unsigned V15_FP     = 4;
  localparam int unsigned V15_SYNC   = 3;
  localparam int unsigned V15_BP     = 15;

  // Position of a counter within one line or one field
  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FP     = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BP     = 2'd3
  } axis_region_e;

  // Number of counts in one period of an axis
  function automatic int unsigned axis_total(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return active + fp + sync + bp;
  endfunction

  // Region lookup. Positions are one bit wider than the counter so that a
  // region end equal to 4096 still compares correctly.
  function automatic axis_region_e axis_region(
    input logic [CNT_W:0] pos,
    input logic [CNT_W:0] act_end,
    input logic [CNT_W:0] fp_end,
    input logic [CNT_W:0] sync_end
  );
    axis_region_e r;
    if (pos < act_end) begin
      r = REG_ACTIVE;
    end else if (pos < fp_end) begin
      r = REG_FP;
    end else if (pos < sync_end) begin
      r = REG_SYNC;
    end else begin
      r = REG_BP;
    end
    return r;
  endfunction

endpackage

// File: rtl/video_sync_axis.sv
// -----------------------------------------------------------------------------
// video_sync_axis
// One timing axis (horizontal or vertical): a wrapping counter plus registered
// sync/blank decode from the four region lengths.
//
// Ports:
//   clk       in  : system clock
//   reset_n   in  : synchronous active-low reset (counter and decode to 0)
//   restart   in  : enter count 0 and decode it, without counting (first
//                   pixel after reset)
//   advance   in  : step the counter by one, wrapping after the last count
//   extend    in  : period is one count longer; the extra count lands in the
//                   back porch (used by the vertical axis in field 1)
//   sync_upd  in  : reload the sync register from the decode of the next
//                   count; lets the vertical sync move on a mid-line pixel
//   cnt       out : current count
//   wrap      out : combinational, high when this advance wraps to 0
//   blank_nxt out : value blank takes at the coming edge
//   sync      out : registered sync, active high
//   blank     out : registered blank, high outside the active region
// -----------------------------------------------------------------------------
module video_sync_axis
  import video_sync_gen_pkg::*;
#(
  parameter int unsigned ACTIVE = H31_ACTIVE,
  parameter int unsigned FP     = H31_FP,
  parameter int unsigned SYNC   = H31_SYNC,
  parameter int unsigned BP     = H31_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  input  logic             advance,
  input  logic             extend,
  input  logic             sync_upd,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             blank_nxt,
  output logic             sync,
  output logic             blank
);

  localparam logic [CNT_W:0] ACT_END_L  = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0] FP_END_L   = (CNT_W+1)'(ACTIVE + FP);
  localparam logic [CNT_W:0] SYNC_END_L = (CNT_W+1)'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W:0] LAST_L     = (CNT_W+1)'(axis_total(ACTIVE, FP, SYNC, BP) - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             sync_r;
  logic             blank_r;
  logic             last_s;
  logic             sync_nxt_s;
  logic             blank_nxt_s;
  axis_region_e     region_nxt_s;

  // Last count of the period; an extended period ends one count later
  always_comb begin
    last_s = ({1'b0, cnt_r} == (LAST_L + {{CNT_W{1'b0}}, extend}));
  end

  // Counter next state: restart forces 0, advance steps or wraps
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (restart) begin
      cnt_nxt_s = '0;
    end else if (advance) begin
      if (last_s) begin
        cnt_nxt_s = '0;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Decode the count the register is about to hold so outputs and counter
  // change on the same edge
  always_comb begin
    region_nxt_s = axis_region({1'b0, cnt_nxt_s}, ACT_END_L, FP_END_L, SYNC_END_L);
    blank_nxt_s  = blank_r;
    sync_nxt_s   = sync_r;
    if (restart || advance) begin
      blank_nxt_s = (region_nxt_s != REG_ACTIVE);
    end else begin
      blank_nxt_s = blank_r;
    end
    if (sync_upd) begin
      sync_nxt_s = (region_nxt_s == REG_SYNC);
    end else begin
      sync_nxt_s = sync_r;
    end
  end

  // Counter and decode registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r   <= '0;
      sync_r  <= 1'b0;
      blank_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      sync_r  <= sync_nxt_s;
      blank_r <= blank_nxt_s;
    end
  end

  assign cnt       = cnt_r;
  assign wrap      = advance & last_s;
  assign blank_nxt = blank_nxt_s;
  assign sync      = sync_r;
  assign blank     = blank_r;

endmodule

// File: rtl/video_sync_gen.sv
// -----------------------------------------------------------------------------
// video_sync_gen
// Programmable raster timing generator. Produces active-high sync, blanking,
// display enable and pixel/line counters, advancing only on ce_pix.
//
// Ports:
//   clk         in  : system clock
//   reset_n     in  : synchronous active-low reset, overrides ce_pix
//   ce_pix      in  : pixel clock enable
//   hsync/vsync out : active-high sync pulses
//   hblank      out : high for hcnt >= H_ACTIVE
//   vblank      out : high for vcnt >= V_ACTIVE
//   de          out : ~hblank & ~vblank
//   hcnt/vcnt   out : 12-bit pixel and line counters
//   field       out : current field (0 unless interlace is compiled in)
//   frame_start out : one-clk pulse when the counters enter (0,0)
//
// Build option VIDEO_SYNC_GEN_INTERLACE_EN: field toggles per field; field 1
// has one extra back-porch line and its vsync edges move to hcnt = H_TOTAL/2.
// Without it every field has V_TOTAL lines and field stays 0.
//
// H_TOTAL and V_TOTAL must be <= 4096 (V_TOTAL < 4096 with interlace).
// -----------------------------------------------------------------------------
module video_sync_gen
  import video_sync_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H31_ACTIVE,
  parameter int unsigned H_FP     = H31_FP,
  parameter int unsigned H_SYNC   = H31_SYNC,
  parameter int unsigned H_BP     = H31_BP,
  parameter int unsigned V_ACTIVE = V31_ACTIVE,
  parameter int unsigned V_FP     = V31_FP,
  parameter int unsigned V_SYNC   = V31_SYNC,
  parameter int unsigned V_BP     = V31_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pix,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             field,
  output logic             frame_start
);

`ifdef VIDEO_SYNC_GEN_INTERLACE_EN
  // Pixel before the half-line point: field 1 vsync reloads as hcnt enters H_TOTAL/2
  localparam logic [CNT_W-1:0] H_HALF_M1_L =
    CNT_W'(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP) / 2 - 1);
`endif

  // After reset the counters sit at (0,0) without having displayed it; the
  // first enabled pixel enters (0,0) instead of stepping past it.
  logic             started_r;
  logic             restart_s;
  logic             h_adv_s;
  logic             v_adv_s;
  logic             h_wrap_s;
  logic             v_wrap_s;
  logic             h_blank_nxt_s;
  logic             v_blank_nxt_s;
  logic             v_sync_upd_s;
  logic             v_extend_s;
  logic [CNT_W-1:0] h_cnt_s;
  logic [CNT_W-1:0] v_cnt_s;
  logic             h_sync_s;
  logic             v_sync_s;
  logic             h_blank_s;
  logic             v_blank_s;
  logic             de_r;
  logic             de_nxt_s;
  logic             frame_start_r;
  logic             field_r;
  logic             field_nxt_s;

  // Pixel strobes: first enable enters (0,0), later enables step the raster
  always_comb begin
    restart_s = ce_pix & ~started_r;
    h_adv_s   = ce_pix & started_r;
    v_adv_s   = h_wrap_s;
  end

  // Field parity, field-1 line extension and vertical sync reload timing
  always_comb begin
    field_nxt_s  = 1'b0;
    v_extend_s   = 1'b0;
    v_sync_upd_s = 1'b0;
`ifdef VIDEO_SYNC_GEN_INTERLACE_EN
    field_nxt_s = field_r ^ v_wrap_s;
    v_extend_s  = field_r;
    if (field_r) begin
      // Half-line offset: vsync follows the line count but changes mid-line
      v_sync_upd_s = h_adv_s & (h_cnt_s == H_HALF_M1_L);
    end else begin
      v_sync_upd_s = restart_s | v_adv_s;
    end
`else
    field_nxt_s  = 1'b0;
    v_extend_s   = 1'b0;
    v_sync_upd_s = restart_s | v_adv_s;
`endif
  end

  video_sync_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (restart_s),
    .advance   (h_adv_s),
    .extend    (1'b0),
    .sync_upd  (restart_s | h_adv_s),
    .cnt       (h_cnt_s),
    .wrap      (h_wrap_s),
    .blank_nxt (h_blank_nxt_s),
    .sync      (h_sync_s),
    .blank     (h_blank_s)
  );

  video_sync_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (restart_s),
    .advance   (v_adv_s),
    .extend    (v_extend_s),
    .sync_upd  (v_sync_upd_s),
    .cnt       (v_cnt_s),
    .wrap      (v_wrap_s),
    .blank_nxt (v_blank_nxt_s),
    .sync      (v_sync_s),
    .blank     (v_blank_s)
  );

  // Display enable follows the blanking values being loaded this edge
  always_comb begin
    de_nxt_s = de_r;
    if (restart_s || h_adv_s) begin
      de_nxt_s = ~h_blank_nxt_s & ~v_blank_nxt_s;
    end else begin
      de_nxt_s = de_r;
    end
  end

  // Start flag, display enable, field parity and frame-start pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      started_r     <= 1'b0;
      de_r          <= 1'b0;
      frame_start_r <= 1'b0;
      field_r       <= 1'b0;
    end else begin
      started_r     <= started_r | ce_pix;
      de_r          <= de_nxt_s;
      frame_start_r <= restart_s | v_wrap_s;
      field_r       <= field_nxt_s;
    end
  end

  assign hsync       = h_sync_s;
  assign vsync       = v_sync_s;
  assign hblank      = h_blank_s;
  assign vblank      = v_blank_s;
  assign de          = de_r;
  assign hcnt        = h_cnt_s;
  assign vcnt        = v_cnt_s;
  assign field       = field_r;
  assign frame_start = frame_start_r;

endmodule
